dac_spi_writer: RTL and testbench



---
 rtl/dac_spi_pkg.sv | 22 ++
 rtl/dac_spi_tick.sv | 45 ++++
 rtl/dac_spi_writer.sv | 174 +++++++++++++++++
 tb/tb_dac_spi_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared types and constants for the serial DAC write engine
package dac_spi_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LDAC
    } dac_state_t;

    localparam int DAC_DATA_W  = 16;
    localparam int DAC_CLK_DIV = 2;

    // Cycles from entering SETUP to re-entering IDLE
    function automatic int frame_cycles(input int data_w, input int clk_div,
                                        input int cs_setup, input int ldac_w);
        return cs_setup + 2 * clk_div * data_w + 1 + ldac_w;
    endfunction

endpackage

// File: rtl/dac_spi_tick.sv
// rtl/dac_spi_tick.sv - SCLK phase divider producing rise/fall ticks
//
// Ports:
//   CLK           system clock
//   RESET         asynchronous active-low reset
//   i_en          run the divider; counter and phase clear while low
//   o_rise_tick   one-cycle pulse at the end of each SCLK low half
//   o_fall_tick   one-cycle pulse at the end of each SCLK high half
module dac_spi_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_en,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;   // 0: SCLK low half, 1: SCLK high half
    logic             w_wrap;

    assign w_wrap      = i_en && (r_cnt == DIV_LAST);
    assign o_rise_tick = w_wrap && !r_phase;
    assign o_fall_tick = w_wrap &&  r_phase;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= !r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_writer.sv
// rtl/dac_spi_writer.sv - buffered 16-bit SPI DAC write engine with LDAC update
//
// Ports:
//   CLK, RESET      system clock, asynchronous active-low reset
//   WR_DATA/WR_STB  core write word and strobe; accepted while WR_READY is high
//   WR_READY        one-word holding buffer is empty
//   BUSY            frame in progress (SETUP through LDAC)
//   DONE            one-cycle pulse when a frame including LDAC completes
//   OVERRUN         sticky: a strobe arrived while the buffer was full
//   CS_N/SCLK/SDI   SPI mode 0 pins, MSB first
//   LDAC_N          DAC load strobe, pulsed after CS_N returns high
module dac_spi_writer
    import dac_spi_pkg::*;
#(
    parameter int DATA_W   = DAC_DATA_W,
    parameter int CLK_DIV  = DAC_CLK_DIV,
    parameter int CS_SETUP = 2,
    parameter int LDAC_W   = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              WR_STB,
    output logic              WR_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERRUN,
    output logic              CS_N,
    output logic              SCLK,
    output logic              SDI,
    output logic              LDAC_N
);

    localparam int BIT_W    = $clog2(DATA_W + 1);
    localparam int WAIT_MAX = (CS_SETUP > LDAC_W) ? CS_SETUP : LDAC_W;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] LDAC_LAST  = WAIT_W'(LDAC_W - 1);

    dac_state_t        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_shreg;
    logic [BIT_W-1:0]  r_bitcnt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic              r_wr_ready, r_busy, r_done, r_overrun;
    logic              r_cs_n, r_sclk, r_ldac_n;
    logic              w_cs_n_nxt, w_sclk_nxt, w_ldac_n_nxt, w_done_nxt;
    logic              w_load, w_rise, w_fall;

    dac_spi_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_en       (r_state == SHIFT),
        .o_rise_tick(w_rise),
        .o_fall_tick(w_fall)
    );

    // Next-state logic; pin values are computed for the next state so they
    // can be registered alongside it.
    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = '0;
        w_cs_n_nxt   = 1'b1;
        w_sclk_nxt   = 1'b0;
        w_ldac_n_nxt = 1'b1;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_wr_ready) begin
                    w_state_nxt = SETUP;
                    w_load      = 1'b1;
                    w_cs_n_nxt  = 1'b0;
                end
            end
            SETUP: begin
                w_cs_n_nxt = 1'b0;
                if (r_wait == SETUP_LAST) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            SHIFT: begin
                w_cs_n_nxt = 1'b0;
                w_sclk_nxt = r_sclk || w_rise;
                if (w_fall) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bitcnt == BIT_LAST) begin
                        w_state_nxt = HOLD;
                        w_cs_n_nxt  = 1'b1;
                    end
                end
            end
            HOLD: begin
                w_state_nxt  = LDAC;
                w_ldac_n_nxt = 1'b0;
            end
            LDAC: begin
                if (r_wait == LDAC_LAST) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ldac_n_nxt = 1'b0;
                    w_wait_nxt   = r_wait + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= IDLE;
            r_wait   <= '0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b0;
            r_ldac_n <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wait   <= w_wait_nxt;
            r_cs_n   <= w_cs_n_nxt;
            r_sclk   <= w_sclk_nxt;
            r_ldac_n <= w_ldac_n_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    // Holding buffer, shift register and bit counter. Accept and drain are
    // mutually exclusive because one needs the buffer empty, the other full.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_buf      <= '0;
            r_wr_ready <= 1'b1;
            r_overrun  <= 1'b0;
            r_shreg    <= '0;
            r_bitcnt   <= '0;
        end else begin
            if (WR_STB && r_wr_ready) begin
                r_buf      <= WR_DATA;
                r_wr_ready <= 1'b0;
            end else if (w_load) begin
                r_wr_ready <= 1'b1;
            end
            if (WR_STB && !r_wr_ready) begin
                r_overrun <= 1'b1;
            end
            if (w_load) begin
                r_shreg  <= r_buf;
                r_bitcnt <= '0;
            end else if ((r_state == SHIFT) && w_fall) begin
                // The final shift empties the register so SDI rests at 0
                r_shreg  <= {r_shreg[DATA_W-2:0], 1'b0};
                r_bitcnt <= (r_bitcnt == BIT_LAST) ? '0 : r_bitcnt + 1'b1;
            end
        end
    end

    assign WR_READY = r_wr_ready;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign OVERRUN  = r_overrun;
    assign CS_N     = r_cs_n;
    assign SCLK     = r_sclk;
    assign SDI      = r_shreg[DATA_W-1];
    assign LDAC_N   = r_ldac_n;

endmodule

// File: tb/tb_dac_spi_writer.sv
// tb/tb_dac_spi_writer.sv - scoreboard bench for dac_spi_writer
module tb_dac_spi_writer;

    localparam int FRAME0 = 69;   // 2 + 2*2*16 + 1 + 2
    localparam int FRAME1 = 35;   // 1 + 2*1*16 + 1 + 1

    logic        CLK, RESET;
    logic [15:0] WR_DATA;
    logic        WR_STB, WR_READY, BUSY, DONE, OVERRUN, CS_N, SCLK, SDI, LDAC_N;
    logic [15:0] b_data;
    logic        b_stb, b_ready, b_busy, b_done, b_ovr, b_cs_n, b_sclk, b_sdi, b_ldac_n;

    dac_spi_writer dut (
        .CLK(CLK), .RESET(RESET), .WR_DATA(WR_DATA), .WR_STB(WR_STB),
        .WR_READY(WR_READY), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN),
        .CS_N(CS_N), .SCLK(SCLK), .SDI(SDI), .LDAC_N(LDAC_N)
    );

    dac_spi_writer #(.DATA_W(16), .CLK_DIV(1), .CS_SETUP(1), .LDAC_W(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .WR_DATA(b_data), .WR_STB(b_stb),
        .WR_READY(b_ready), .BUSY(b_busy), .DONE(b_done), .OVERRUN(b_ovr),
        .CS_N(b_cs_n), .SCLK(b_sclk), .SDI(b_sdi), .LDAC_N(b_ldac_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one-word buffer in front of an engine that is busy
    // for FRAME0 cycles after each drain edge.
    typedef struct {
        logic [15:0] w;
        int          en;   // edge on which CS_N is expected to fall
    } exp_t;
    exp_t        sb[$];
    logic        m_full, m_ovr;
    logic [15:0] m_buf;
    int          m_idle_from;

    task automatic model_step(input logic stb, input logic [15:0] d, input int n);
        logic full_before;
        exp_t e;
        full_before = m_full;
        if (full_before && (n - 1 >= m_idle_from)) begin
            e.w = m_buf;
            e.en = n;
            sb.push_back(e);
            m_idle_from = n + FRAME0;
            m_full = 1'b0;
        end
        if (stb && !full_before) begin
            m_buf  = d;
            m_full = 1'b1;
        end
        if (stb && full_before) m_ovr = 1'b1;
    endtask

    task automatic cycle(input logic stb, input logic [15:0] d);
        @(negedge CLK);
        check("wr_ready", WR_READY, !m_full);
        check("overrun", OVERRUN, m_ovr);
        WR_STB  = stb;
        WR_DATA = d;
        model_step(stb, d, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0);
    endtask

    // DAC-side monitor for the default-parameter instance
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_sdi = 1'b0, p_ldac = 1'b1;
    logic        mf_in = 1'b0, done_pend = 1'b0;
    logic [15:0] mf_word;
    int          mf_rises = 0, mf_fall = 0, mf_last_rise = -1000, mf_gap = 0;
    int          exp_done = 0, busy_cnt = 0, ldac_cnt = 0, ldac_pulses = 0;

    initial forever begin
        @(negedge CLK);
        if (!RESET) begin
            mf_in = 1'b0; done_pend = 1'b0; busy_cnt = 0; ldac_cnt = 0;
        end else begin
            if (p_cs && !CS_N) begin
                mf_in = 1'b1; mf_fall = cyc; mf_rises = 0; mf_word = 16'h0;
                mf_gap = cyc - mf_last_rise;
            end
            if (!p_sclk && SCLK) begin
                check("sclk_rise_cs_low", CS_N, 1'b0);
                mf_word = {mf_word[14:0], SDI};
                mf_rises++;
            end
            if (p_sclk && SCLK) check("sdi_stable_high", SDI, p_sdi);
            if (CS_N) check("sclk_idle_cs_high", SCLK, 1'b0);
            if (!LDAC_N) begin
                check("ldac_cs_high", CS_N, 1'b1);
                ldac_cnt++;
            end else if (!p_ldac) begin
                check("ldac_width", ldac_cnt, 2);
                ldac_pulses++;
                ldac_cnt = 0;
            end
            if (!p_cs && CS_N && mf_in) begin
                mf_in = 1'b0;
                mf_last_rise = cyc;
                check("frame_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dac_word", mf_word, e.w);
                    check("sclk_rises", mf_rises, 16);
                    check("cs_fall_edge", mf_fall, e.en);
                    exp_done  = e.en + FRAME0;
                    done_pend = 1'b1;
                end
            end
            if (BUSY) busy_cnt++;
            if (DONE) begin
                check("done_expected", done_pend, 1'b1);
                check("done_edge", cyc, exp_done);
                check("busy_span", busy_cnt, FRAME0);
                busy_cnt = 0;
                done_pend = 1'b0;
            end
        end
        p_cs = CS_N; p_sclk = SCLK; p_sdi = SDI; p_ldac = LDAC_N;
    end

    // Lightweight monitor for the fast-parameter instance
    logic        q_cs = 1'b1, q_sclk = 1'b0, q_ldac = 1'b1;
    logic [15:0] b_word = 16'h0;
    int          b_fall = 0, b_rises = 0, b_first = 0, b_last = 0, b_done_cyc = 0, b_ldac_cnt = 0;

    initial forever begin
        @(negedge CLK);
        if (RESET) begin
            if (q_cs && !b_cs_n) begin
                b_fall = cyc; b_rises = 0; b_word = 16'h0; b_ldac_cnt = 0;
            end
            if (!q_sclk && b_sclk) begin
                if (b_rises == 0) b_first = cyc;
                b_last = cyc;
                b_word = {b_word[14:0], b_sdi};
                b_rises++;
            end
            if (!b_ldac_n) b_ldac_cnt++;
            if (b_done) b_done_cyc = cyc;
        end
        q_cs = b_cs_n; q_sclk = b_sclk; q_ldac = b_ldac_n;
    end

    int acc, wait_n, pulses_before;

    initial begin
        RESET = 1'b0; WR_STB = 1'b0; WR_DATA = 16'h0; b_stb = 1'b0; b_data = 16'h0;
        m_full = 1'b0; m_ovr = 1'b0; m_buf = 16'h0; m_idle_from = 0;
        repeat (3) @(negedge CLK);
        check("rst_cs_n", CS_N, 1'b1);
        check("rst_sclk", SCLK, 1'b0);
        check("rst_sdi", SDI, 1'b0);
        check("rst_ldac_n", LDAC_N, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_overrun", OVERRUN, 1'b0);
        check("rst_wr_ready", WR_READY, 1'b1);
        #1 RESET = 1'b1;
        m_idle_from = cyc;

        // Single write
        idle(2);
        cycle(1'b1, 16'hA5C3);
        idle(80);

        // Back-to-back: second word queued mid-frame
        cycle(1'b1, 16'h0001);
        idle(20);
        cycle(1'b1, 16'hFFFF);
        idle(160);
        check("b2b_overrun", OVERRUN, 1'b0);
        check("b2b_cs_gap", mf_gap, 4);

        // Fast instance: CLK_DIV=1, CS_SETUP=1, LDAC_W=1
        cycle(1'b0, 16'h0);
        b_stb = 1'b1; b_data = 16'h8000; acc = cyc + 1;
        cycle(1'b0, 16'h0);
        b_stb = 1'b0;
        idle(50);
        check("fast_cs_fall", b_fall, acc + 1);
        check("fast_word", b_word, 16'h8000);
        check("fast_rises", b_rises, 16);
        check("fast_rise_spacing", b_last - b_first, 30);
        check("fast_frame", b_done_cyc - b_fall, FRAME1);
        check("fast_ldac_width", b_ldac_cnt, 1);
        check("fast_overrun", b_ovr, 1'b0);

        // Three strobes on consecutive cycles from idle
        cycle(1'b1, 16'h1111);
        cycle(1'b1, 16'h2222);
        cycle(1'b1, 16'h3333);
        idle(160);
        check("triple_overrun", OVERRUN, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 15) == 0, 16'($urandom));
        idle(160);
        check("overrun_sticky", OVERRUN, 1'b1);

        // Reset part-way through a frame
        cycle(1'b1, 16'hBEEF);
        wait_n = 0;
        while (!(mf_in && mf_rises >= 7 && mf_fall > cyc - 100) && wait_n < 300) begin
            cycle(1'b0, 16'h0);
            wait_n++;
        end
        check("reset_wait_timeout", wait_n < 300, 1'b1);
        pulses_before = ldac_pulses;
        #1 RESET = 1'b0;
        WR_STB = 1'b0;
        #1;
        check("abort_cs_n", CS_N, 1'b1);
        check("abort_sclk", SCLK, 1'b0);
        check("abort_sdi", SDI, 1'b0);
        check("abort_ldac_n", LDAC_N, 1'b1);
        check("abort_busy", BUSY, 1'b0);
        check("abort_done", DONE, 1'b0);
        check("abort_overrun", OVERRUN, 1'b0);
        check("abort_wr_ready", WR_READY, 1'b1);
        sb.delete();
        m_full = 1'b0; m_ovr = 1'b0;
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b1;
        m_idle_from = cyc;
        idle(10);
        check("abort_no_ldac", ldac_pulses, pulses_before);
        cycle(1'b1, 16'h1234);
        idle(90);
        check("post_abort_ldac", ldac_pulses, pulses_before + 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
